// File: rtl/ptw_pkg.sv
// Shared page-table-walker types and constants: PTE layout and default bus widths.
// No logic, so no latency and no backpressure.
package ptw_pkg;
    localparam int PTW_ADDR_W      = 48;
    localparam int PTW_DATA_W      = 64;
    localparam int PTE_PRESENT_BIT = 0;
    localparam int PTE_PA_LSB      = 12;

    typedef struct packed {
        logic [PTW_DATA_W-1:PTE_PA_LSB]    ppn;
        logic [PTE_PA_LSB-1:PTE_PRESENT_BIT+1] attr;
        logic                              present;
    } pte_t;
endpackage

// File: rtl/pte_resp_fifo.sv
// Generic synchronous FIFO, W bits x DEPTH entries, head shown combinationally.
// Latency: one cycle from push to a non-empty head.
// Backpressure: a push while full or a pop while empty is ignored; the caller gates both.
module pte_resp_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;
endmodule

// File: rtl/pte_read_responder.sv
// PTE store answering each accepted AR with one in-order R beat; PTE_RESP_FAULT_INJ_EN adds present-bit fault injection.
// Latency: LATENCY cycles from AR handshake to earliest rvalid.
// Backpressure: arready drops once MAX_OUT reads are outstanding; rvalid/rdata hold until rready.
module pte_read_responder
    import ptw_pkg::*;
#(
    parameter int ADDR_W   = PTW_ADDR_W,
    parameter int DATA_W   = PTW_DATA_W,
    parameter int IDX_W    = 6,
    parameter int ADDR_LSB = 0,
    parameter int LATENCY  = 2,
    parameter int MAX_OUT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_arvalid,
    output logic              mem_arready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    input  logic              mem_rready,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [31:0]       stat_reads
`ifdef PTE_RESP_FAULT_INJ_EN
    ,
    input  logic              inj_en,
    input  logic [IDX_W-1:0]  inj_idx
`endif
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int OCC_W = $clog2(MAX_OUT + LATENCY + 2) + 1;

    logic [DATA_W-1:0] table_q [DEPTH];
    logic [IDX_W-1:0]  ar_idx;
    logic              ar_hs;
    logic              r_hs;
    logic [DATA_W-1:0] cap_dat;
    logic              dl_vld_q [LATENCY];
    logic [DATA_W-1:0] dl_dat_q [LATENCY];
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic              arready_q;
    logic [31:0]       stat_q;
    logic              unused_araddr;

    // Only the index field decodes; the remaining address bits alias.
    assign unused_araddr = ^mem_araddr;
    assign ar_idx        = mem_araddr[ADDR_LSB +: IDX_W];
    assign ar_hs         = mem_arvalid && arready_q;
    assign r_hs          = mem_rvalid && mem_rready;

    always_comb begin
        cap_dat = table_q[ar_idx];
`ifdef PTE_RESP_FAULT_INJ_EN
        if (inj_en && (ar_idx == inj_idx)) cap_dat[PTE_PRESENT_BIT] = 1'b0;
`endif
    end

    // Table read is combinational, so a same-cycle write is seen only by later reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (wr_en) begin
            table_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_vld_q[i] <= 1'b0;
                dl_dat_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0] <= ar_hs;
            dl_dat_q[0] <= cap_dat;
            for (int i = 1; i < LATENCY; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_dat_q[i] <= dl_dat_q[i-1];
            end
        end
    end

    pte_resp_fifo #(
        .W     (DATA_W),
        .DEPTH (MAX_OUT)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (dl_vld_q[LATENCY-1]),
        .push_dat (dl_dat_q[LATENCY-1]),
        .pop      (r_hs),
        .head_dat (fifo_head),
        .count    (fifo_cnt),
        .empty    (fifo_empty)
    );

    assign mem_rvalid = !fifo_empty;
    assign mem_rdata  = fifo_empty ? '0 : fifo_head;

    always_comb begin
        occ = OCC_W'(fifo_cnt);
        for (int i = 0; i < LATENCY; i++) occ = occ + OCC_W'(dl_vld_q[i]);
        occ_nxt = occ + OCC_W'(ar_hs) - OCC_W'(r_hs);
    end

    // arready is registered from next-cycle occupancy: a pop frees its slot one cycle later
    // and rready has no combinational path to arready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready_q <= 1'b0;
            stat_q    <= '0;
        end else begin
            arready_q <= (occ_nxt < OCC_W'(MAX_OUT));
            if (ar_hs) stat_q <= stat_q + 32'd1;
        end
    end

    assign mem_arready = arready_q;
    assign stat_reads  = stat_q;
endmodule

// File: tb/tb_pte_read_responder.sv
// Randomised scoreboard bench for pte_read_responder: stimulus pushes expected R data, a monitor pops and compares.
module tb_pte_read_responder;
    localparam int ADDR_W  = 48;
    localparam int DATA_W  = 64;
    localparam int IDX_W   = 6;
    localparam int LATENCY = 2;
    localparam int MAX_OUT = 4;
    localparam int TBL     = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_araddr = '0;
    logic              mem_arvalid = 1'b0;
    logic              mem_arready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_rready;
    logic              wr_en = 1'b0;
    logic [IDX_W-1:0]  wr_idx = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [31:0]       stat_reads;
`ifdef PTE_RESP_FAULT_INJ_EN
    logic              inj_en = 1'b0;
    logic [IDX_W-1:0]  inj_idx = '0;
`endif

    always #5 clk = ~clk;

    pte_read_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .ADDR_LSB (0),
        .LATENCY  (LATENCY),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .stat_reads  (stat_reads)
`ifdef PTE_RESP_FAULT_INJ_EN
        ,
        .inj_en      (inj_en),
        .inj_idx     (inj_idx)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] model [TBL];
    logic [DATA_W-1:0] exp_q [$];
    int                acc_q [$];
    int                cyc = 0;
    int                edges_since = 0;
    int                rr_mode = 0;
    int                last_lat = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) edges_since = 0;
            else edges_since++;
        end
    end

    // rready pattern generator: 0 = hold low, 1 = high, 2 = random, 3 = toggle
    initial begin
        mem_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       mem_rready = 1'b0;
                1:       mem_rready = 1'b1;
                2:       mem_rready = 1'($urandom_range(0, 1));
                default: mem_rready = ~mem_rready;
            endcase
        end
    end

    // Monitor: outputs sampled at negedge, describing handshakes at the coming edge.
    initial begin
        int               ar_seen;
        int               r_seen;
        bit               prev_hold;
        logic [DATA_W-1:0] prev_dat;
        logic [DATA_W-1:0] e;
        int               a;
        ar_seen = 0; r_seen = 0; prev_hold = 0; prev_dat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ar_seen = 0; r_seen = 0; prev_hold = 0;
            end else begin
                check("stat_reads", 64'(stat_reads), 64'(ar_seen));
                check("arready", 64'(mem_arready),
                      64'((edges_since >= 1) && ((ar_seen - r_seen) < MAX_OUT)));
                if (prev_hold) begin
                    check("r_hold_valid", 64'(mem_rvalid), 64'd1);
                    check("r_hold_data", mem_rdata, prev_dat);
                end
                if (mem_rvalid && mem_rready) begin
                    if (exp_q.size() == 0) begin
                        check("r_unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("r_data", mem_rdata, e);
                        last_lat = cyc - a;
                        n_chk++;
                        if (last_lat < LATENCY) begin
                            n_fail++;
                            $display("FAIL r_latency: got %0d cycles, expected at least %0d", last_lat, LATENCY);
                        end
                    end
                    r_seen++;
                end
                if (mem_arvalid && mem_arready) ar_seen++;
                prev_hold = mem_rvalid && !mem_rready;
                prev_dat  = mem_rdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (wr_en) model[wr_idx] = wr_data;
        #1;
    endtask

    task automatic wr_only(input int idx, input logic [DATA_W-1:0] dat);
        wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_data = dat;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_ar(input int idx, input bit do_wr, input int widx, input logic [DATA_W-1:0] wdat);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] e;
        bit ok;
        a = ADDR_W'({$urandom(), $urandom()});
        a[IDX_W-1:0] = IDX_W'(idx);
        mem_araddr  = a;
        mem_arvalid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 200; w++) begin
            if (mem_arready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("ar_accept", 64'(ok), 64'd1);
        if (ok) begin
            if (do_wr) begin
                wr_en = 1'b1; wr_idx = IDX_W'(widx); wr_data = wdat;
            end
            e = model[idx];
`ifdef PTE_RESP_FAULT_INJ_EN
            if (inj_en && (IDX_W'(idx) == inj_idx)) e[0] = 1'b0;
`endif
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            tick();
            wr_en = 1'b0;
        end
        mem_arvalid = 1'b0;
    endtask

    task automatic drain();
        rr_mode = 1;
        for (int w = 0; w < 300; w++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < TBL; i++) model[i] = '0;
        #2;
        check("reset_arready", 64'(mem_arready), 64'd0);
        check("reset_rvalid", 64'(mem_rvalid), 64'd0);
        check("reset_rdata", mem_rdata, 64'd0);
        check("reset_stat", 64'(stat_reads), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single read, exact latency
        wr_only(3, 64'h0000_0000_0012_3001);
        rr_mode = 1;
        tick();
        do_ar(3, 0, 0, '0);
        drain();
        check("t1_latency", 64'(last_lat), 64'(LATENCY));
        check("t1_stat", 64'(stat_reads), 64'd1);

        // Fill to MAX_OUT with rready low, then release
        for (int i = 1; i <= 5; i++) wr_only(i, 64'h1000 + 64'(i));
        rr_mode = 0;
        tick();
        for (int i = 1; i <= 4; i++) do_ar(i, 0, 0, '0);
        repeat (3) tick();
        check("t2_arready_low", 64'(mem_arready), 64'd0);
        check("t2_pending", 64'(exp_q.size()), 64'd4);
        fork
            do_ar(5, 0, 0, '0);
            begin
                repeat (4) @(posedge clk);
                rr_mode = 3;
            end
        join
        drain();

        // Same-cycle write and read: read sees old data
        wr_only(7, 64'h5551);
        do_ar(7, 1, 7, 64'hAAA1);
        do_ar(7, 0, 0, '0);
        drain();

        // Long rready stall
        rr_mode = 0;
        do_ar(9, 0, 0, '0);
        do_ar(10, 0, 0, '0);
        repeat (LATENCY + 10) tick();
        check("t4_rvalid_held", 64'(mem_rvalid), 64'd1);
        check("t4_pending", 64'(exp_q.size()), 64'd2);
        drain();

        // Reset with reads outstanding
        rr_mode = 0;
        for (int i = 0; i < 3; i++) do_ar(3, 0, 0, '0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rvalid", 64'(mem_rvalid), 64'd0);
        check("t5_arready", 64'(mem_arready), 64'd0);
        check("t5_stat", 64'(stat_reads), 64'd0);
        check("t5_rdata", mem_rdata, 64'd0);
        exp_q.delete();
        acc_q.delete();
        for (int i = 0; i < TBL; i++) model[i] = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        do_ar(3, 0, 0, '0);
        drain();

`ifdef PTE_RESP_FAULT_INJ_EN
        wr_only(3, 64'h0000_0000_0012_3001);
        inj_en = 1'b1; inj_idx = 6'd3;
        do_ar(3, 0, 0, '0);
        do_ar(4, 0, 0, '0);
        drain();
        inj_en = 1'b0;
`endif

        // Randomised mix of writes, reads, aliasing and backpressure
        rr_mode = 2;
        for (int n = 0; n < 150; n++) begin
            int idx;
            int widx;
            idx = int'($urandom_range(0, 15));
            widx = ($urandom_range(0, 1) == 1) ? idx : int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                wr_only(idx, {$urandom(), $urandom()});
            else
                do_ar(idx, $urandom_range(0, 2) == 0, widx, {$urandom(), $urandom()});
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
